// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 geometry shared by the controller, frame memory
// and test code, plus the common counter and pixel types.
package vga_pkg;

   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BACK   = 48;
   localparam int H_ACTIVE = 640;
   localparam int V_FRONT  = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 33;
   localparam int V_ACTIVE = 480;

   localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int H_ACT_LO = H_SYNC + H_BACK;
   localparam int H_ACT_HI = H_ACT_LO + H_ACTIVE - 1;
   localparam int V_ACT_LO = V_SYNC + V_BACK;
   localparam int V_ACT_HI = V_ACT_LO + V_ACTIVE - 1;

   localparam int CNT_W    = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/vga_if.sv
// vga_if: raster position and region decodes from the timing counter
// to the output stage.
interface vga_if;
   import vga_pkg::*;

   cnt_t h_cnt;
   cnt_t v_cnt;
   logic h_act;
   logic v_act;
   logic h_sync;
   logic v_sync;

   modport master (
      output h_cnt, v_cnt, h_act, v_act, h_sync, v_sync
   );

   modport slave (
      input h_cnt, v_cnt, h_act, v_act, h_sync, v_sync
   );

endinterface

// File: rtl/vga_timing_cnt.sv
// vga_timing_cnt: free-running h/v raster counters and the
// combinational active/sync region decodes.
module vga_timing_cnt #(
   parameter int H_FRONT  = vga_pkg::H_FRONT,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BACK   = vga_pkg::H_BACK,
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int V_FRONT  = vga_pkg::V_FRONT,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BACK   = vga_pkg::V_BACK,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
   input logic   clk,
   input logic   rst,
   vga_if.master tim
);
   import vga_pkg::*;

   localparam int LN_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int FR_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

   localparam cnt_t H_LAST = cnt_t'(LN_TOT - 1);
   localparam cnt_t V_LAST = cnt_t'(FR_TOT - 1);
   localparam cnt_t H_LO   = cnt_t'(H_SYNC + H_BACK);
   localparam cnt_t H_HI   = cnt_t'(H_SYNC + H_BACK + H_ACTIVE - 1);
   localparam cnt_t V_LO   = cnt_t'(V_SYNC + V_BACK);
   localparam cnt_t V_HI   = cnt_t'(V_SYNC + V_BACK + V_ACTIVE - 1);
   localparam cnt_t H_SY   = cnt_t'(H_SYNC);
   localparam cnt_t V_SY   = cnt_t'(V_SYNC);

   cnt_t r_h_cnt;
   cnt_t r_v_cnt;

   // Line advance and frame wrap happen on the same edge as the h wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   assign tim.h_cnt  = r_h_cnt;
   assign tim.v_cnt  = r_v_cnt;
   assign tim.h_act  = (r_h_cnt >= H_LO) && (r_h_cnt <= H_HI);
   assign tim.v_act  = (r_v_cnt >= V_LO) && (r_v_cnt <= V_HI);
   assign tim.h_sync = (r_h_cnt < H_SY);
   assign tim.v_sync = (r_v_cnt < V_SY);

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA raster controller; maps the raster to frame-memory
// addresses and registers sync, blank and colour one cycle later.
module vga_ctrl #(
   parameter int H_FRONT  = vga_pkg::H_FRONT,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BACK   = vga_pkg::H_BACK,
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int V_FRONT  = vga_pkg::V_FRONT,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BACK   = vga_pkg::V_BACK,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] vga_data,
   output logic [9:0]  h_addr,
   output logic [9:0]  v_addr,
   output logic        VGA_HSYNC,
   output logic        VGA_VSYNC,
   output logic        VGA_BLANK_N,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        frame_start
);
   import vga_pkg::*;

   localparam cnt_t H_LO = cnt_t'(H_SYNC + H_BACK);
   localparam cnt_t V_LO = cnt_t'(V_SYNC + V_BACK);

   vga_if tim ();

   vga_timing_cnt #(
      .H_FRONT  (H_FRONT),
      .H_SYNC   (H_SYNC),
      .H_BACK   (H_BACK),
      .H_ACTIVE (H_ACTIVE),
      .V_FRONT  (V_FRONT),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK),
      .V_ACTIVE (V_ACTIVE)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .tim (tim)
   );

   logic w_act;
   logic w_first;
   rgb_t w_pix;

   assign w_act   = tim.h_act & tim.v_act;
   assign w_first = (tim.h_cnt == H_LO) && (tim.v_cnt == V_LO);
   assign w_pix   = rgb_t'(vga_data);

   assign h_addr  = tim.h_act ? tim.h_cnt - H_LO : '0;
   assign v_addr  = tim.v_act ? tim.v_cnt - V_LO : '0;

   logic r_hsync;
   logic r_vsync;
   logic r_blank_n;
   logic r_first;
   rgb_t r_rgb;

   // Memory data is gated to black outside the window before registering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
         r_blank_n <= 1'b0;
         r_first   <= 1'b0;
         r_rgb     <= '0;
      end else begin
         r_hsync   <= ~tim.h_sync;
         r_vsync   <= ~tim.v_sync;
         r_blank_n <= w_act;
         r_first   <= w_first;
         r_rgb     <= w_act ? w_pix : '0;
      end
   end

   assign VGA_HSYNC   = r_hsync;
   assign VGA_VSYNC   = r_vsync;
   assign VGA_BLANK_N = r_blank_n;
   assign frame_start = r_first;
   assign VGA_R       = r_rgb.r;
   assign VGA_G       = r_rgb.g;
   assign VGA_B       = r_rgb.b;

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-002 Parameter H_SYNC, 96, horizontal sync pulse width in pixels.
REQ-003 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-004 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-005 Parameter V_FRONT, 10; V_SYNC, 2; V_BACK, 33; V_ACTIVE, 480: vertical equivalents, in lines.
REQ-006 Port clk, input, 1: pixel clock (25 MHz nominal); the only clock in the block.
REQ-007 Port rst, input, 1: reset, asynchronous and active-low.
REQ-008 Port vga_data, input, 24: pixel {R,G,B} from the frame memory for the address presented in the same cycle.
REQ-009 Port h_addr, output, 10: horizontal pixel address, combinational from the counters.
REQ-010 Port v_addr, output, 10: vertical pixel address, combinational from the counters.
REQ-011 Ports VGA_HSYNC and VGA_VSYNC, output, 1 each: sync signals, active-low.
REQ-012 Port VGA_BLANK_N, output, 1: high while registered RGB is visible.
REQ-013 Ports VGA_R, VGA_G and VGA_B, output, 8 each: registered colour.
REQ-014 Port frame_start, output, 1: one-cycle pulse aligned with the first visible pixel of a frame on the outputs.

Function
REQ-015 Total line length H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (800); frame length V_TOTAL is defined the same way (525); both SHALL be derived, never entered as literals.
REQ-016 h_cnt SHALL count 0..H_TOTAL-1, increment every cycle and wrap to 0.
REQ-017 v_cnt SHALL increment only in the cycle where h_cnt wraps, and SHALL wrap to 0 after V_TOTAL-1 in that same cycle.
REQ-018 Horizontal active region SHALL be h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1], i.e. [144,783]; vertical active region SHALL be v_cnt in [35,514].
REQ-019 Horizontal sync region SHALL be h_cnt < H_SYNC; vertical sync region SHALL be v_cnt < V_SYNC.
REQ-020 h_addr SHALL equal h_cnt-144 inside the active region and 0 outside it; v_addr SHALL equal v_cnt-35 inside the active region and 0 outside it.
REQ-021 Output latency SHALL be 1 cycle: VGA_HSYNC, VGA_VSYNC, VGA_BLANK_N and RGB for counter state N SHALL appear after the clock edge that ends cycle N.
REQ-022 VGA_R/G/B SHALL register vga_data[23:16], [15:8] and [7:0] when both regions are active, and SHALL register 0 otherwise.
REQ-023 frame_start SHALL be high for exactly one cycle per frame, in the output cycle of h_cnt=144, v_cnt=35.
REQ-024 No input SHALL stall the counters; the block is free-running.

Reset
REQ-025 While rst=0: h_cnt=0, v_cnt=0, VGA_HSYNC=1, VGA_VSYNC=1, VGA_BLANK_N=0, RGB=0, frame_start=0.
REQ-026 Reset asserted mid-line SHALL force these values immediately; the first edge after release SHALL register the state for h_cnt=0, v_cnt=0 (HSYNC=0, VSYNC=0).

Structure
REQ-027 Timing parameters and derived totals/region bounds SHALL live in a shared package, vga_pkg, so the frame-memory and test code use identical geometry.
REQ-028 A single sub-module, vga_timing_cnt, SHALL hold the h/v counters and the region decodes; vga_ctrl SHALL add the address mapping and output register stage.

Verification
REQ-029 Release reset, then count edges -> HSYNC low for exactly 96 cycles and one HSYNC falling edge every 800 cycles.
REQ-030 Run 2 frames -> VSYNC low for exactly 1600 cycles (2 lines) per 420000-cycle frame; frame_start pulses exactly twice, 420000 cycles apart.
REQ-031 Drive vga_data={h_addr[7:0],v_addr[7:0],8'hA5} -> at output pixel (h=10,v=3): R=0x0A, G=0x03, B=0xA5, BLANK_N=1, one cycle after the counters reach h_cnt=154, v_cnt=38.
REQ-032 Drive vga_data=24'hFFFFFF throughout -> RGB=0 and BLANK_N=0 for every output cycle outside the active window (e.g. h_cnt=784..799, any v_cnt in 515..524).
REQ-033 Assert rst at h_cnt=500, v_cnt=200 for 3 cycles -> outputs take reset values asynchronously; after release, the timing matches a fresh start (first frame_start 28144 cycles after the first edge).
REQ-034 Check addresses at the boundaries -> h_addr: 0 at h_cnt=144, 639 at 783, 0 at 784; v_addr: 479 at v_cnt=514, 0 at v_cnt=515.
